// File: rtl/wbconsole_if.sv
// Wishbone slave bus bundle for the console port.
// Carries cycle/strobe/write/address/data towards the slave and ack/stall/data back.
// The master drives requests, the slave answers one cycle later and never stalls.
interface wbconsole_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wbconsole.sv
// Wishbone console port with RX/TX character FIFOs, sticky overflows and thresholded interrupts.
// Latency: bus ack/data one cycle after strobe; RX char visible one cycle after i_console_stb.
// Backpressure: bus never stalls; TX drains only while !i_console_busy; full FIFOs drop and flag.
module wbconsole #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  wbconsole_if.slave    wb,
  output logic          o_console_stb,
  output logic [BW-1:0] o_console_data,
  input  logic          i_console_busy,
  input  logic          i_console_stb,
  input  logic [BW-1:0] i_console_data,
  output logic          o_rx_int,
  output logic          o_rxfifo_int,
  output logic          o_tx_int,
  output logic          o_txfifo_int,
  output logic          o_int
);
  localparam int D  = 1 << LGFLEN;
  localparam int FW = LGFLEN + 1;

  logic [BW-1:0]     rx_mem [D];
  logic [BW-1:0]     tx_mem [D];
  logic [LGFLEN-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic [FW-1:0]     rx_fill, tx_fill;
  logic              rx_ovf, tx_ovf;
  logic [10:0]       rx_thr, tx_thr;
  logic [3:0]        int_en;

  logic        bus, rx_sel, tx_sel, setup_sel;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rx_pop, rx_flush, rx_push, rx_ovf_set;
  logic        tx_pop, tx_flush, tx_push, tx_ovf_set, tx_wr;
  logic [BW-1:0] rx_head, tx_head;
  logic [31:0] rd_dat;

  assign wb.o_wb_stall = 1'b0;

  // Decode bus access and FIFO push/pop/flush qualifiers for this cycle.
  always_comb begin
    bus       = wb.i_wb_cyc && wb.i_wb_stb;
    setup_sel = bus && (wb.i_wb_addr == 2'd0);
    rx_sel    = bus && (wb.i_wb_addr == 2'd2);
    tx_sel    = bus && (wb.i_wb_addr == 2'd3);
    rx_empty  = (rx_fill == '0);
    rx_full   = (rx_fill == FW'(D));
    tx_empty  = (tx_fill == '0);
    tx_full   = (tx_fill == FW'(D));
    rx_head   = rx_empty ? '0 : rx_mem[rx_rptr];
    tx_head   = tx_empty ? '0 : tx_mem[tx_rptr];
    // A full RX FIFO can still take a character when the bus pops in the same cycle.
    rx_pop     = rx_sel && !wb.i_wb_we && !rx_empty;
    rx_flush   = rx_sel && wb.i_wb_we && wb.i_wb_data[12];
    rx_push    = i_console_stb && (!rx_full || rx_pop) && !rx_flush;
    rx_ovf_set = i_console_stb && rx_full && !rx_pop && !rx_flush;
    tx_pop     = !tx_empty && !i_console_busy;
    tx_flush   = tx_sel && wb.i_wb_we && wb.i_wb_data[12];
    tx_wr      = tx_sel && wb.i_wb_we && !wb.i_wb_data[12];
    tx_push    = tx_wr && (!tx_full || tx_pop);
    tx_ovf_set = tx_wr && tx_full && !tx_pop;
  end

  // Read-data mux, sampled from state in the strobe cycle.
  always_comb begin
    rd_dat = '0;
    case (wb.i_wb_addr)
      2'd0: begin
        rd_dat[10:0]  = rx_thr;
        rd_dat[26:16] = tx_thr;
        rd_dat[31:28] = int_en;
      end
      2'd1: rd_dat = {4'(LGFLEN), 12'(tx_fill), 4'(LGFLEN), 12'(rx_fill)};
      2'd2: begin
        rd_dat[31:16]  = 16'(rx_fill);
        rd_dat[12]     = rx_ovf;
        rd_dat[8]      = rx_empty;
        rd_dat[BW-1:0] = rx_head;
      end
      default: begin
        rd_dat[31:16]  = 16'(tx_fill);
        rd_dat[12]     = tx_ovf;
        rd_dat[9]      = tx_full;
        rd_dat[8]      = !tx_empty;
        rd_dat[BW-1:0] = tx_head;
      end
    endcase
  end

  // FIFO storage; occupancy is tracked separately so no reset is needed here.
  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wptr] <= i_console_data;
    if (tx_push) tx_mem[tx_wptr] <= wb.i_wb_data[BW-1:0];
  end

  // Control state: pointers, fills, stickies, SETUP and the registered bus response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wptr      <= '0;
      rx_rptr      <= '0;
      rx_fill      <= '0;
      rx_ovf       <= 1'b0;
      tx_wptr      <= '0;
      tx_rptr      <= '0;
      tx_fill      <= '0;
      tx_ovf       <= 1'b0;
      rx_thr       <= 11'(D / 2);
      tx_thr       <= 11'(D / 2);
      int_en       <= '0;
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_data <= '0;
    end else begin
      wb.o_wb_ack <= bus;
      if (bus) wb.o_wb_data <= rd_dat;

      if (rx_flush) begin
        rx_wptr <= '0;
        rx_rptr <= '0;
        rx_fill <= '0;
        rx_ovf  <= 1'b0;
      end else begin
        if (rx_push) rx_wptr <= rx_wptr + LGFLEN'(1);
        if (rx_pop)  rx_rptr <= rx_rptr + LGFLEN'(1);
        rx_fill <= rx_fill + FW'(rx_push) - FW'(rx_pop);
        if (rx_ovf_set) rx_ovf <= 1'b1;
      end

      if (tx_flush) begin
        tx_wptr <= '0;
        tx_rptr <= '0;
        tx_fill <= '0;
        tx_ovf  <= 1'b0;
      end else begin
        if (tx_push) tx_wptr <= tx_wptr + LGFLEN'(1);
        if (tx_pop)  tx_rptr <= tx_rptr + LGFLEN'(1);
        tx_fill <= tx_fill + FW'(tx_push) - FW'(tx_pop);
        if (tx_ovf_set) tx_ovf <= 1'b1;
      end

      if (setup_sel && wb.i_wb_we) begin
        rx_thr <= wb.i_wb_data[10:0];
        tx_thr <= wb.i_wb_data[26:16];
        int_en <= wb.i_wb_data[31:28];
      end
    end
  end

  // Console output and interrupts derive from registered state only.
  always_comb begin
    o_console_stb  = !tx_empty;
    o_console_data = tx_head;
    o_rx_int       = !rx_empty;
    o_rxfifo_int   = (11'(rx_fill) >= rx_thr);
    o_tx_int       = !tx_full;
    o_txfifo_int   = (11'(tx_fill) <= tx_thr);
    o_int          = |({o_txfifo_int, o_tx_int, o_rxfifo_int, o_rx_int} & int_en);
  end
endmodule

// File: tb/tb_wbconsole.sv
// Directed bench for wbconsole with BW=8, LGFLEN=4 (D=16).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_wbconsole;
  logic       clk = 1'b0;
  logic       rst;
  logic       console_stb_o;
  logic [7:0] console_data_o;
  logic       console_busy;
  logic       console_stb_i;
  logic [7:0] console_data_i;
  logic       rx_int, rxfifo_int, tx_int, txfifo_int, irq;
  int         checks = 0;
  int         failures = 0;
  logic [31:0] rd;

  wbconsole_if wb ();

  wbconsole #(.BW(8), .LGFLEN(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .wb             (wb),
    .o_console_stb  (console_stb_o),
    .o_console_data (console_data_o),
    .i_console_busy (console_busy),
    .i_console_stb  (console_stb_i),
    .i_console_data (console_data_i),
    .o_rx_int       (rx_int),
    .o_rxfifo_int   (rxfifo_int),
    .o_tx_int       (tx_int),
    .o_txfifo_int   (txfifo_int),
    .o_int          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_stb  = 1'b0;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = 2'd0;
    wb.i_wb_data = 32'h0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b1;
    wb.i_wb_addr = a;
    wb.i_wb_data = d;
    tick();
    bus_idle();
  endtask

  task automatic wb_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_addr = a;
    tick();
    bus_idle();
    check({tag, "_ack"}, 32'(wb.o_wb_ack), 32'h1);
    check(tag, wb.o_wb_data, exp);
  endtask

  task automatic rx_inject(input logic [7:0] c);
    console_stb_i  = 1'b1;
    console_data_i = c;
    tick();
    console_stb_i  = 1'b0;
    console_data_i = 8'h0;
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    console_busy   = 1'b0;
    console_stb_i  = 1'b0;
    console_data_i = 8'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ack", 32'(wb.o_wb_ack), 32'h0);
    check("rst_wbdat", wb.o_wb_data, 32'h0);
    check("rst_cstb", 32'(console_stb_o), 32'h0);
    check("rst_cdat", 32'(console_data_o), 32'h0);
    check("rst_ints", {27'h0, irq, txfifo_int, tx_int, rxfifo_int, rx_int}, 32'h0000_000c);
    wb_read("fifo_rst", 2'd1, 32'h4000_4000);
    wb_read("setup_rst", 2'd0, 32'h0008_0008);

    // TX path held off by busy, then drained
    console_busy = 1'b1;
    wb_write(2'd3, 32'h41);
    check("tx_first_stb", 32'(console_stb_o), 32'h1);
    check("tx_first_dat", 32'(console_data_o), 32'h41);
    wb_write(2'd3, 32'h42);
    wb_read("txreg_2", 2'd3, 32'h0002_0141);
    repeat (5) tick();
    check("tx_hold_dat", 32'(console_data_o), 32'h41);
    console_busy = 1'b0;
    check("tx_drain0", {23'h0, console_stb_o, console_data_o}, 32'h141);
    tick();
    check("tx_drain1", {23'h0, console_stb_o, console_data_o}, 32'h142);
    tick();
    check("tx_drain2", {23'h0, console_stb_o, console_data_o}, 32'h000);

    // RX overflow: 17 characters into a 16-deep FIFO
    for (int i = 0; i < 17; i++) rx_inject(8'(i));
    check("rx_full_ints", {27'h0, irq, txfifo_int, tx_int, rxfifo_int, rx_int}, 32'h0000_000f);
    wb_read("rxreg_ovf", 2'd2, 32'h0010_1000);
    wb_read("fifo_rx15", 2'd1, 32'h4000_400f);
    wb_write(2'd2, 32'h0000_1000);
    wb_read("rxreg_flushed", 2'd2, 32'h0000_0100);
    check("rx_int_flushed", 32'(rx_int), 32'h0);

    // RX threshold interrupt
    wb_write(2'd0, 32'h2000_0003);
    wb_read("setup_wr", 2'd0, 32'h2000_0003);
    rx_inject(8'hA1);
    rx_inject(8'hA2);
    check("thr_below", {30'h0, irq, rxfifo_int}, 32'h0);
    rx_inject(8'hA3);
    check("thr_reach", {30'h0, irq, rxfifo_int}, 32'h3);
    wb_read("rxreg_thr", 2'd2, 32'h0003_00A1);
    check("thr_fall", {30'h0, irq, rxfifo_int}, 32'h0);

    // TX full, simultaneous pop and write
    console_busy = 1'b1;
    for (int i = 0; i < 16; i++) wb_write(2'd3, 32'h60 + 32'(i));
    wb_read("txreg_full", 2'd3, 32'h0010_0360);
    check("tx_int_full", 32'(tx_int), 32'h0);
    console_busy = 1'b0;
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_we   = 1'b1;
    wb.i_wb_addr = 2'd3;
    wb.i_wb_data = 32'h55;
    tick();
    console_busy = 1'b1;
    bus_idle();
    wb_read("txreg_popwr", 2'd3, 32'h0010_0361);
    wb_write(2'd3, 32'h77);
    wb_read("txreg_ovf", 2'd3, 32'h0010_1361);
    wb_write(2'd3, 32'h0000_1000);
    wb_read("txreg_flush", 2'd3, 32'h0000_0000);
    check("tx_int_flush", 32'(tx_int), 32'h1);
    console_busy = 1'b0;

    // Reset arriving together with an RX read strobe drops the ack
    wb.i_wb_cyc  = 1'b1;
    wb.i_wb_stb  = 1'b1;
    wb.i_wb_addr = 2'd2;
    rst = 1'b1;
    tick();
    bus_idle();
    check("rr_ack", 32'(wb.o_wb_ack), 32'h0);
    check("rr_wbdat", wb.o_wb_data, 32'h0);
    check("rr_cons", {23'h0, console_stb_o, console_data_o}, 32'h0);
    check("rr_ints", {27'h0, irq, txfifo_int, tx_int, rxfifo_int, rx_int}, 32'h0000_000c);
    rst = 1'b0;
    tick();
    check("rr_ack_later", 32'(wb.o_wb_ack), 32'h0);
    wb_read("setup_rr", 2'd0, 32'h0008_0008);
    wb_read("fifo_rr", 2'd1, 32'h4000_4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
